// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction fields into 32-bit words and
// streams them, with their byte addresses, through a single-entry output
// register toward the instruction-memory write port.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A producer holds its payload stable while valid=1 and ready=0; valid never
// depends on ready. Here in_ready = !out_valid || out_ready, so a held word
// that is being taken this cycle frees the register for a new field set in
// the same cycle.
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_seen,
  output logic [15:0]       word_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       instr_q, instr_d;
  logic              err_q, err_d;
  logic              err_seen_q, err_seen_d;
  logic [15:0]       count_q, count_d;
  // Word index; the byte address drops its two low zero bits.
  logic [ADDR_W-3:0] idx_q, idx_d;

  logic        accept;
  logic        handoff;
  logic [31:0] enc_instr;
  logic        enc_err;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid_q && out_ready;

  // Field packing selected by opcode; unknown opcodes become a flagged NOP.
  always_comb begin
    enc_instr = NOP_WORD;
    enc_err   = 1'b0;
    unique case (in_opcode)
      OP_R: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      OP_IMM: begin
        // Shift-immediate forms carry funct7 above a 5-bit shift amount.
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          enc_instr = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
        else
          enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      OP_LOAD, OP_JALR, OP_SYSTEM:
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      OP_STORE:
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      OP_BRANCH: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_err   = in_imm[0];
      end
      OP_LUI, OP_AUIPC:
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
      OP_JAL: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err   = in_imm[0];
      end
      default: begin
        enc_instr = NOP_WORD;
        enc_err   = 1'b1;
      end
    endcase
  end

  // Next-state for the output register and handoff counters.
  always_comb begin
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    err_d       = err_q;
    err_seen_d  = err_seen_q;
    count_d     = count_q;
    idx_d       = idx_q;
    if (accept) begin
      out_valid_d = 1'b1;
      instr_d     = enc_instr;
      err_d       = enc_err;
    end else if (handoff) begin
      out_valid_d = 1'b0;
    end
    if (handoff) begin
      count_d    = count_q + 16'd1;
      idx_d      = idx_q + 1'b1;
      err_seen_d = err_seen_q | err_q;
    end
  end

  // State register with synchronous reset; a held word is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      err_q       <= 1'b0;
      err_seen_q  <= 1'b0;
      count_q     <= '0;
      idx_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      err_seen_q  <= err_seen_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_instr  = instr_q;
  assign out_err    = err_q;
  assign err_seen   = err_seen_q;
  assign word_count = count_q;
  assign out_addr   = BASE_ADDR + {idx_q, 2'b00};

endmodule
